// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: byte-delivery port of the uart_rx_os receiver.
// The master side (the receiver) presents a byte with its parity and
// framing flags on a valid/ready handshake. Overrun is reported on the same bundle.
interface uart_rx_os_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver (start, 8 data LSB first,
// parity, 1 stop). Bytes are held in a one-entry valid/ready output
// register. If a new frame completes while that register is still full,
// the new frame is dropped and the sticky overrun flag is set.
// Optional build macro UART_RX_MAJORITY_EN: each line sample is a 2-of-3
// vote over the ticks P-2, P-1 and P. Without the macro, the receiver
// takes a single sample at tick P.
module uart_rx_os #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  output logic          busy,
  uart_rx_os_if.master  rx_if
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  START_MID = OS_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } state_t;

  // Expected parity bit for a data byte.
  function automatic logic parity_bit(input logic [7:0] d);
    logic p;
    if (PARITY_ODD) begin
      p = ~^d;
    end else begin
      p = ^d;
    end
    return p;
  endfunction

  logic              rx_meta_r;
  logic              rxs_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [OS_W-1:0]   os_cnt_r;
  logic [2:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  state_t            state_r;
  logic              perr_r;
  logic              ferr_r;
  logic              deliver_r;
  logic              busy_r;

  logic [7:0]        rx_data_r;
  logic              rx_valid_r;
  logic              parity_err_r;
  logic              frame_err_r;
  logic              overrun_r;

  logic              tick_s;
  logic [OS_W-1:0]   point_s;
  logic              mid_s;
  logic              sample_s;

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // Tick strobe and the nominal sample point for the current state.
  always_comb begin
    tick_s  = (div_cnt_r == DIV_LAST);
    if (state_r == ST_START) begin
      point_s = START_MID;
    end else begin
      point_s = OS_LAST;
    end
    mid_s = tick_s && (os_cnt_r == point_s);
  end

`ifdef UART_RX_MAJORITY_EN
  // Two-of-three majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic vote0_r;
  logic vote1_r;

  // Capture the two early votes at P-2 and P-1 ahead of each sample point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote0_r <= 1'b1;
      vote1_r <= 1'b1;
    end else if (tick_s) begin
      if (os_cnt_r == (point_s - OS_W'(2))) begin
        vote0_r <= rxs_r;
      end
      if (os_cnt_r == (point_s - OS_W'(1))) begin
        vote1_r <= rxs_r;
      end
    end
  end

  // Voted line sample used by every state.
  always_comb begin
    sample_s = maj3(vote0_r, vote1_r, rxs_r);
  end
`else
  // Single line sample taken at the nominal point.
  always_comb begin
    sample_s = rxs_r;
  end
`endif

  // Receive FSM with tick divider, oversample and bit counters, and shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      os_cnt_r  <= {OS_W{1'b0}};
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      state_r   <= ST_IDLE;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      deliver_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      deliver_r <= 1'b0;

      if (tick_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
        if (os_cnt_r == OS_LAST) begin
          os_cnt_r <= {OS_W{1'b0}};
        end else begin
          os_cnt_r <= os_cnt_r + OS_W'(1);
        end
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end

      case (state_r)
        ST_IDLE: begin
          if (!rxs_r) begin
            // Re-phase the bit timing to the detected falling edge.
            div_cnt_r <= {DIV_W{1'b0}};
            os_cnt_r  <= {OS_W{1'b0}};
            state_r   <= ST_START;
            busy_r    <= 1'b1;
          end
        end
        ST_START: begin
          if (mid_s) begin
            if (sample_s) begin
              // Line went back high: a glitch, not a start bit.
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              os_cnt_r  <= {OS_W{1'b0}};
              bit_cnt_r <= 3'd0;
              state_r   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (mid_s) begin
            shift_r <= {sample_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (mid_s) begin
            perr_r  <= sample_s ^ parity_bit(shift_r);
            state_r <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (mid_s) begin
            ferr_r    <= ~sample_s;
            deliver_r <= 1'b1;
            if (sample_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_BRK;
            end
          end
        end
        ST_BRK: begin
          // A held-low line must rise before another start can be seen.
          if (rxs_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output register: deliver, drop with overrun, or consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (deliver_r) begin
      if (!rx_valid_r || rx_if.rx_ready) begin
        rx_data_r    <= shift_r;
        parity_err_r <= perr_r;
        frame_err_r  <= ferr_r;
        rx_valid_r   <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (rx_valid_r && rx_if.rx_ready) begin
      rx_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end
  end

  assign rx_if.rx_data    = rx_data_r;
  assign rx_if.rx_valid   = rx_valid_r;
  assign rx_if.parity_err = parity_err_r;
  assign rx_if.frame_err  = frame_err_r;
  assign rx_if.overrun    = overrun_r;
  assign busy             = busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os at 160 clk per bit
// (CLK_FREQ=1.6 MHz, BAUD_RATE=10 kbit/s, OVERSAMPLE=16, odd parity).
module tb_uart_rx_os;

  logic clk;
  logic rst;
  logic rx;
  logic busy;

  uart_rx_os_if rx_if ();

  uart_rx_os #(
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16),
    .PARITY_ODD (1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .busy  (busy),
    .rx_if (rx_if)
  );

  localparam int BIT_CLK = 160;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         frame_cnt = 0;
  int         t_start  = 0;
  int         cap_cyc  = 0;
  int         base_cnt = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;
  logic       prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: every rising edge of rx_valid is one delivered frame.
  always @(negedge clk) begin
    if (rx_if.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      frame_cnt = frame_cnt + 1;
      cap_data  = rx_if.rx_data;
      cap_perr  = rx_if.parity_err;
      cap_ferr  = rx_if.frame_err;
      cap_cyc   = cyc;
    end
    prev_valid = rx_if.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    clks(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    rx_if.rx_ready = 1'b1;
    clks(5);

    // Reset values
    check("rst_data",   {24'h0, rx_if.rx_data},  32'h0);
    check("rst_valid",  {31'h0, rx_if.rx_valid}, 32'h0);
    check("rst_perr",   {31'h0, rx_if.parity_err}, 32'h0);
    check("rst_ferr",   {31'h0, rx_if.frame_err}, 32'h0);
    check("rst_ovr",    {31'h0, rx_if.overrun},  32'h0);
    check("rst_busy",   {31'h0, busy},           32'h0);
    rst = 1'b1;
    clks(20);

    // Good frame 0xA5, odd parity bit 1
    send_frame(8'hA5, 1'b1, 1'b1);
    clks(20);
    check("a5_count", frame_cnt, 32'd1);
    check("a5_data",  {24'h0, cap_data}, 32'hA5);
    check("a5_perr",  {31'h0, cap_perr}, 32'h0);
    check("a5_ferr",  {31'h0, cap_ferr}, 32'h0);
    check("a5_ovr",   {31'h0, rx_if.overrun}, 32'h0);
    check("a5_busy",  {31'h0, busy}, 32'h0);
    check("a5_valid_gone", {31'h0, rx_if.rx_valid}, 32'h0);
    check("a5_latency_window",
          {31'h0, ((cap_cyc - t_start) >= 1682) && ((cap_cyc - t_start) <= 1686)}, 32'h1);

    // 0x3C with wrong parity bit (correct odd parity would be 1)
    send_frame(8'h3C, 1'b0, 1'b1);
    clks(20);
    check("3c_count", frame_cnt, 32'd2);
    check("3c_data",  {24'h0, cap_data}, 32'h3C);
    check("3c_perr",  {31'h0, cap_perr}, 32'h1);
    check("3c_ferr",  {31'h0, cap_ferr}, 32'h0);

    // 0x00 with stop bit 0, then line held low 20 bit times
    send_frame(8'h00, 1'b1, 1'b0);
    rx = 1'b0;
    clks(20 * BIT_CLK);
    check("brk_count", frame_cnt, 32'd3);
    check("brk_data",  {24'h0, cap_data}, 32'h00);
    check("brk_ferr",  {31'h0, cap_ferr}, 32'h1);
    check("brk_busy_held", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    clks(10);
    check("brk_busy_idle", {31'h0, busy}, 32'h0);
    clks(2 * BIT_CLK);
    check("brk_no_extra", frame_cnt, 32'd3);

    // 30-clk glitch from idle
    base_cnt = frame_cnt;
    rx = 1'b0;
    clks(10);
    check("glitch_busy_on", {31'h0, busy}, 32'h1);
    clks(20);
    rx = 1'b1;
    clks(200);
    check("glitch_busy_off", {31'h0, busy}, 32'h0);
    check("glitch_no_frame", frame_cnt - base_cnt, 32'd0);
    check("glitch_valid", {31'h0, rx_if.rx_valid}, 32'h0);
    check("glitch_ovr",   {31'h0, rx_if.overrun}, 32'h0);

    // Overrun: rx_ready low, 0x11 then 0x22 back-to-back
    rx_if.rx_ready = 1'b0;
    base_cnt = frame_cnt;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    clks(20);
    check("ovr_one_rise", frame_cnt - base_cnt, 32'd1);
    check("ovr_valid", {31'h0, rx_if.rx_valid}, 32'h1);
    check("ovr_data",  {24'h0, rx_if.rx_data}, 32'h11);
    check("ovr_flag",  {31'h0, rx_if.overrun}, 32'h1);
    check("ovr_perr",  {31'h0, rx_if.parity_err}, 32'h0);
    rx_if.rx_ready = 1'b1;
    clks(1);
    rx_if.rx_ready = 1'b0;
    check("ovr_cons_valid", {31'h0, rx_if.rx_valid}, 32'h0);
    check("ovr_cons_flag",  {31'h0, rx_if.overrun}, 32'h0);
    clks(5);
    rx_if.rx_ready = 1'b1;

    // Reset during data bit 4 of 0x77, then a clean 0x5A
    rx = 1'b0;
    clks(BIT_CLK);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    clks(40);
    rst = 1'b0;
    clks(1);
    check("mid_rst_data",  {24'h0, rx_if.rx_data},  32'h0);
    check("mid_rst_valid", {31'h0, rx_if.rx_valid}, 32'h0);
    check("mid_rst_perr",  {31'h0, rx_if.parity_err}, 32'h0);
    check("mid_rst_ferr",  {31'h0, rx_if.frame_err}, 32'h0);
    check("mid_rst_ovr",   {31'h0, rx_if.overrun},  32'h0);
    check("mid_rst_busy",  {31'h0, busy},           32'h0);
    clks(2);
    rst = 1'b1;
    clks(2 * BIT_CLK);
    base_cnt = frame_cnt;
    send_frame(8'h5A, 1'b1, 1'b1);
    clks(2 * BIT_CLK);
    check("post_rst_count", frame_cnt - base_cnt, 32'd1);
    check("post_rst_data",  {24'h0, cap_data}, 32'h5A);
    check("post_rst_perr",  {31'h0, cap_perr}, 32'h0);
    check("post_rst_ferr",  {31'h0, cap_ferr}, 32'h0);
    check("post_rst_ovr",   {31'h0, rx_if.overrun}, 32'h0);
    check("post_rst_busy",  {31'h0, busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
